// File: rtl/spi_master_ctrl_if.sv
// TX/RX word handshake bundle between a host and the SPI master controller.
// The controller takes the slave modport; the word source/sink takes master.
interface spi_master_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master transaction controller: CS setup/hold sequencing, any CPOL/CPHA,
// MSB-first words, multi-word bursts under one CS assertion.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpol,
  input  logic                 cpha,
  output logic                 busy,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs_n,
  spi_master_ctrl_if.slave     bus
);

  localparam int unsigned MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_CNT = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned EDGES   = 2 * DATA_W;
  localparam int unsigned EC_W    = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    NEXT,
    HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              last_q;
  logic              cpol_q;
  logic              cpha_q;

  // edge_cnt holds k-1 for the edge about to be generated; odd k is leading
  logic lead_c;
  logic final_trail_c;
  logic half_done_c;
  logic accept_c;

  assign lead_c        = ~edge_cnt[0];
  assign final_trail_c = (edge_cnt == EC_W'(EDGES - 1));
  assign half_done_c   = (cnt == CNT_W'(CLK_DIV - 1));
  assign accept_c      = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      edge_cnt     <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      last_q       <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      busy         <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          spi_cs_n     <= 1'b1;
          spi_sclk     <= cpol;
          busy         <= 1'b0;
          bus.tx_ready <= 1'b1;
          if (accept_c) begin
            tx_sh        <= bus.tx_data;
            last_q       <= bus.tx_last;
            cpol_q       <= cpol;
            cpha_q       <= cpha;
            if (!cpha) spi_mosi <= bus.tx_data[DATA_W-1];
            spi_cs_n     <= 1'b0;
            busy         <= 1'b1;
            bus.tx_ready <= 1'b0;
            cnt          <= '0;
            state        <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt      <= '0;
            edge_cnt <= '0;
            state    <= XFER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        XFER: begin
          if (!half_done_c) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (edge_cnt == EC_W'(EDGES)) begin
              // extra idle half-period elapsed: word complete
              bus.rx_valid <= 1'b1;
              bus.rx_data  <= rx_sh;
              bus.tx_ready <= !last_q;
              state        <= last_q ? HOLD : NEXT;
            end else begin
              spi_sclk <= ~spi_sclk;
              edge_cnt <= edge_cnt + EC_W'(1);
              if (lead_c ^ cpha_q) rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
              if (cpha_q && lead_c) begin
                spi_mosi <= tx_sh[DATA_W-1];
                tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
              end
              if (!cpha_q && !lead_c && !final_trail_c) begin
                spi_mosi <= tx_sh[DATA_W-2];
                tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
              end
            end
          end
        end

        NEXT: begin
          // CS stays low; next word starts straight into XFER with the burst mode
          if (accept_c) begin
            tx_sh        <= bus.tx_data;
            last_q       <= bus.tx_last;
            if (!cpha_q) spi_mosi <= bus.tx_data[DATA_W-1];
            bus.tx_ready <= 1'b0;
            cnt          <= '0;
            edge_cnt     <= '0;
            state        <= XFER;
          end
        end

        HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            cnt          <= '0;
            spi_cs_n     <= 1'b1;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: directed words, expected RX queued at
// issue time and checked by an independent monitor on every rx_valid.
module tb_spi_master_ctrl;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned WORD_LAT = (2 * DATA_W + 1) * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic busy, spi_sclk, spi_mosi, spi_miso, spi_cs_n;

  spi_master_ctrl_if #(.DATA_W(DATA_W)) bus ();

  spi_master_ctrl #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpol    (cpol),
    .cpha    (cpha),
    .busy    (busy),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // slave-side mode the bench expects the DUT to be running in
  logic tb_cpol = 1'b0;
  logic tb_cpha = 1'b0;
  logic loopback = 1'b1;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic slave_miso = 1'b0;
  logic s_prev = 1'b0;

  assign spi_miso = loopback ? spi_mosi : slave_miso;

  // monitor statistics
  int cyc = 0;
  int rx_cnt = 0, rxv_cyc = 0;
  int cs_fall_cnt = 0, cs_fall_cyc = 0;
  int cs_rise_cnt = 0, cs_rise_cyc = 0;
  int lead_cnt = 0;
  logic cs_prev = 1'b1;
  logic m_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Behavioural SPI slave, evaluated away from the DUT clock edge
  initial begin
    forever begin
      @(negedge clk);
      if (spi_cs_n) begin
        slave_sh   = slave_word;
        slave_miso = slave_word[7];
      end else if (spi_sclk != s_prev) begin
        if (s_prev == tb_cpol) begin
          if (!tb_cpha) slave_rx = {slave_rx[6:0], spi_mosi};
          else begin
            slave_miso = slave_sh[7];
            slave_sh   = {slave_sh[6:0], 1'b0};
          end
        end else begin
          if (tb_cpha) slave_rx = {slave_rx[6:0], spi_mosi};
          else begin
            slave_sh   = {slave_sh[6:0], 1'b0};
            slave_miso = slave_sh[7];
          end
        end
      end
      s_prev = spi_sclk;
    end
  end

  // Monitor: scoreboard pop on rx_valid plus CS/SCLK event bookkeeping
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rx_valid) begin
        rx_cnt++;
        rxv_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no word", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e));
        end
      end
      if (cs_prev && !spi_cs_n) begin cs_fall_cnt++; cs_fall_cyc = cyc; end
      if (!cs_prev && spi_cs_n) begin cs_rise_cnt++; cs_rise_cyc = cyc; end
      if (!spi_cs_n && (spi_sclk != m_prev) && (m_prev == tb_cpol)) lead_cnt++;
      cs_prev = spi_cs_n;
      m_prev  = spi_sclk;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake, tx_valid left high
  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] exp);
    int n;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    exp_q.push_back(exp);
    n = 0;
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("send_ready");
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("wait_idle");
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    while (!bus.rx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("wait_rx");
  endtask

  initial begin
    int l0, f0, r0, c0, bad, edges, n;
    logic p;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", 32'(bus.tx_ready), 32'd1);

    // mode 0, loopback, single word
    l0 = lead_cnt;
    send(8'hA5, 1'b1, 8'hA5);
    bus.tx_valid = 1'b0;
    check("m0_busy", 32'(busy), 32'd1);
    check("m0_cs_low", 32'(spi_cs_n), 32'd0);
    check("m0_mosi_msb", 32'(spi_mosi), 32'd1);
    check("m0_ready_low", 32'(bus.tx_ready), 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("m0_rising_edges", 32'(lead_cnt - l0), 32'd8);
    check("m0_latency", 32'(rxv_cyc - cs_fall_cyc), 32'(CS_SETUP + WORD_LAT));
    check("m0_cs_hold", 32'(cs_rise_cyc - rxv_cyc), 32'(CS_HOLD));

    // mode 3 against slave model
    cpol = 1'b1; cpha = 1'b1; tb_cpol = 1'b1; tb_cpha = 1'b1;
    loopback = 1'b0; slave_word = 8'h3C;
    repeat (2) @(negedge clk);
    check("m3_sclk_idle", 32'(spi_sclk), 32'd1);
    send(8'hC3, 1'b1, 8'h3C);
    bus.tx_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("m3_slave_rx", 32'(slave_rx), 32'hC3);
    check("m3_sclk_end", 32'(spi_sclk), 32'd1);

    // mode 0 burst, tx_valid held
    cpol = 1'b0; cpha = 1'b0; tb_cpol = 1'b0; tb_cpha = 1'b0; loopback = 1'b1;
    repeat (2) @(negedge clk);
    l0 = lead_cnt; f0 = cs_fall_cnt; r0 = cs_rise_cnt; c0 = rx_cnt;
    send(8'h11, 1'b0, 8'h11);
    send(8'h22, 1'b0, 8'h22);
    send(8'h33, 1'b1, 8'h33);
    bus.tx_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("burst_cs_falls", 32'(cs_fall_cnt - f0), 32'd1);
    check("burst_cs_rises", 32'(cs_rise_cnt - r0), 32'd1);
    check("burst_rx_count", 32'(rx_cnt - c0), 32'd3);
    check("burst_lead_edges", 32'(lead_cnt - l0), 32'd24);
    check("burst_span", 32'(rxv_cyc - cs_fall_cyc), 32'(CS_SETUP + 3 * WORD_LAT + 2));

    // burst with a 20-cycle gap in NEXT
    send(8'h96, 1'b0, 8'h96);
    bus.tx_valid = 1'b0;
    wait_rx();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b0 || spi_sclk !== 1'b0 || bus.tx_ready !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("gap_next_hold", 32'(bad), 32'd0);
    send(8'h69, 1'b1, 8'h69);
    bus.tx_valid = 1'b0;
    wait_idle();

    // mode 1, cpol toggled mid-word
    cpol = 1'b0; cpha = 1'b1; tb_cpol = 1'b0; tb_cpha = 1'b1;
    repeat (2) @(negedge clk);
    l0 = lead_cnt;
    send(8'hB7, 1'b1, 8'hB7);
    bus.tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    cpol = 1'b1;
    wait_idle();
    check("m1_lead_edges", 32'(lead_cnt - l0), 32'd8);
    repeat (2) @(negedge clk);
    check("m1_idle_follows_cpol", 32'(spi_sclk), 32'd1);

    // reset at edge 5 of a word, then a fresh transfer
    cpol = 1'b0; cpha = 1'b0; tb_cpha = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hE1, 1'b1, 8'hE1);
    bus.tx_valid = 1'b0;
    edges = 0; n = 0; p = spi_sclk;
    while (edges < 5 && n < 200) begin
      @(negedge clk);
      if (spi_sclk != p) edges++;
      p = spi_sclk;
      n++;
    end
    if (n >= 200) timeout("edge5");
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    c0 = rx_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_rx", 32'(rx_cnt - c0), 32'd0);
    send(8'h5A, 1'b1, 8'h5A);
    bus.tx_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("post_reset_rx", 32'(rx_cnt - c0), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
